// File: rtl/mux_scan_seq.sv
// Registered N:1 channel selector with MANUAL select and a SCAN sweep FSM.
// Data selection is a one-hot AND-OR tree built from per-channel lane gates.

module mux_scan_lane #(
  parameter int W = 1
) (
  input  logic         hit,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  assign q = {W{hit}} & d;
endmodule

module mux_scan_seq #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] I,
  input  logic [SEL_W-1:0]  S,
  input  logic              mode,
  input  logic              en,
  output logic [W-1:0]      F,
  output logic [SEL_W-1:0]  F_ch,
  output logic              valid,
  output logic              sel_err,
  output logic              sweep_done
);
  localparam int CH_W = $clog2(N_CH);
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]  NCH_L   = (SEL_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH-1);
  localparam logic [DW_W-1:0] LAST_DW = DW_W'(DWELL-1);

  typedef enum logic {ST_IDLE, ST_DWELL} state_t;

  state_t              state;
  logic [CH_W-1:0]     ch_cnt;
  logic [DW_W-1:0]     dwell_cnt;
  logic [SEL_W-1:0]    pick;
  logic                s_bad, last_dw, last_ch;
  logic [N_CH-1:0][W-1:0] lane_q;
  logic [W-1:0]        sel_data;

  assign s_bad   = {1'b0, S} >= NCH_L;
  assign last_dw = (dwell_cnt == LAST_DW);
  assign last_ch = (ch_cnt == LAST_CH);

  // Entering SCAN always samples channel 0; out-of-range S matches no lane.
  always_comb begin
    pick = S;
    if (mode) pick = (state == ST_DWELL) ? SEL_W'(ch_cnt) : '0;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mux_scan_lane #(.W(W)) u_lane (
      .hit (pick == SEL_W'(k)),
      .d   (I[k*W +: W]),
      .q   (lane_q[k])
    );
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) sel_data = sel_data | lane_q[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ch_cnt     <= '0;
      dwell_cnt  <= '0;
      F          <= '0;
      F_ch       <= '0;
      valid      <= 1'b0;
      sel_err    <= 1'b0;
      sweep_done <= 1'b0;
    end else if (!en) begin
      valid      <= 1'b0;
      sweep_done <= 1'b0;
    end else if (!mode) begin
      state      <= ST_IDLE;
      ch_cnt     <= '0;
      dwell_cnt  <= '0;
      F          <= sel_data;
      F_ch       <= S;
      valid      <= ~s_bad;
      sel_err    <= s_bad;
      sweep_done <= 1'b0;
    end else if (state == ST_IDLE) begin
      state      <= ST_DWELL;
      ch_cnt     <= '0;
      dwell_cnt  <= '0;
      F          <= sel_data;
      F_ch       <= '0;
      valid      <= 1'b0;
      sel_err    <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      F          <= sel_data;
      F_ch       <= SEL_W'(ch_cnt);
      valid      <= last_dw;
      sel_err    <= 1'b0;
      sweep_done <= last_dw & last_ch;
      if (last_dw) begin
        dwell_cnt <= '0;
        ch_cnt    <= last_ch ? '0 : ch_cnt + CH_W'(1);
      end else begin
        dwell_cnt <= dwell_cnt + DW_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mux_scan_seq.sv
// Scoreboard bench: A (8 ch, DWELL=4) and B (6 ch, DWELL=1), W=4.
// Strobe items are popped on valid; per-cycle checks are popped by cycle number.
module tb_mux_scan_seq;
  logic clk = 1'b0, rst_n;
  logic [31:0] i_a;
  logic [23:0] i_b;
  logic [2:0]  s_a, s_b, ch_a, ch_b;
  logic        mode_a, mode_b, en_a, en_b;
  logic [3:0]  f_a, f_b;
  logic        va_a, va_b, se_a, se_b, sd_a, sd_b;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  bit          done = 1'b0;

  typedef struct {logic [3:0] f; logic [2:0] ch; logic sd; logic se; string nm;} sb_t;
  typedef struct {int cyc; bit b; logic [3:0] f; logic [2:0] ch; logic v; logic se; logic sd; string nm;} ck_t;
  sb_t qa[$], qb[$];
  ck_t qc[$];

  mux_scan_seq #(.N_CH(8), .W(4), .SEL_W(3), .DWELL(4)) u_a (
    .clk(clk), .rst_n(rst_n), .I(i_a), .S(s_a), .mode(mode_a), .en(en_a),
    .F(f_a), .F_ch(ch_a), .valid(va_a), .sel_err(se_a), .sweep_done(sd_a));

  mux_scan_seq #(.N_CH(6), .W(4), .SEL_W(3), .DWELL(1)) u_b (
    .clk(clk), .rst_n(rst_n), .I(i_b), .S(s_b), .mode(mode_b), .en(en_b),
    .F(f_b), .F_ch(ch_b), .valid(va_b), .sel_err(se_b), .sweep_done(sd_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: the only process that compares and counts.
  always @(negedge clk) begin
    sb_t e;
    ck_t c;
    logic [10:0] got, req;
    if (va_a === 1'b1) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++; $display("FAIL a_unexpected_valid got F=%h ch=%0d exp none", f_a, ch_a);
      end else begin
        e = qa.pop_front();
        if ({f_a, ch_a, sd_a, se_a} !== {e.f, e.ch, e.sd, e.se}) begin
          n_bad++;
          $display("FAIL a_%s got F=%h ch=%0d sd=%b se=%b exp F=%h ch=%0d sd=%b se=%b",
                   e.nm, f_a, ch_a, sd_a, se_a, e.f, e.ch, e.sd, e.se);
        end
      end
    end else if (sd_a === 1'b1) begin
      n_cmp++; n_bad++; $display("FAIL a_sweep_without_valid got sd=1 exp 0");
    end
    if (va_b === 1'b1) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++; $display("FAIL b_unexpected_valid got F=%h ch=%0d exp none", f_b, ch_b);
      end else begin
        e = qb.pop_front();
        if ({f_b, ch_b, sd_b, se_b} !== {e.f, e.ch, e.sd, e.se}) begin
          n_bad++;
          $display("FAIL b_%s got F=%h ch=%0d sd=%b se=%b exp F=%h ch=%0d sd=%b se=%b",
                   e.nm, f_b, ch_b, sd_b, se_b, e.f, e.ch, e.sd, e.se);
        end
      end
    end else if (sd_b === 1'b1) begin
      n_cmp++; n_bad++; $display("FAIL b_sweep_without_valid got sd=1 exp 0");
    end
    while (qc.size() != 0 && qc[0].cyc <= cyc) begin
      c = qc.pop_front();
      n_cmp++;
      got = c.b ? {f_b, ch_b, va_b, se_b, sd_b} : {f_a, ch_a, va_a, se_a, sd_a};
      req = {c.f, c.ch, c.v, c.se, c.sd};
      if (c.cyc != cyc || got !== req) begin
        n_bad++;
        $display("FAIL %s (cyc %0d) got {F,ch,v,se,sd}=%h exp %h", c.nm, c.cyc, got, req);
      end
    end
    if (done) begin
      if (qa.size() + qb.size() + qc.size() != 0) begin
        n_cmp++; n_bad++;
        $display("FAIL leftover_expectations got %0d pending exp 0", qa.size() + qb.size() + qc.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input bit b, input logic [3:0] f, input logic [2:0] ch,
                     input logic v, input logic se, input logic sd, input string nm);
    ck_t c;
    c.cyc = cyc + 1; c.b = b; c.f = f; c.ch = ch; c.v = v; c.se = se; c.sd = sd; c.nm = nm;
    qc.push_back(c);
  endtask

  task automatic exp_s(input bit b, input logic [3:0] f, input logic [2:0] ch,
                       input logic sd, input logic se, input string nm);
    sb_t e;
    e.f = f; e.ch = ch; e.sd = sd; e.se = se; e.nm = nm;
    if (b) qb.push_back(e); else qa.push_back(e);
  endtask

  initial begin
    logic [7:0] pat;
    logic [3:0] exp1 [8];
    int ch;
    pat  = 8'b1010_0110;
    exp1 = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    s_a = '0; s_b = '0;
    for (int k = 0; k < 8; k++) i_a[k*4 +: 4] = {3'b0, pat[k]};
    for (int k = 0; k < 6; k++) i_b[k*4 +: 4] = 4'(k + 9);
    step(); step();
    chk(0, 4'd0, 3'd0, 0, 0, 0, "reset_a");
    chk(1, 4'd0, 3'd0, 0, 0, 0, "reset_b");
    step();
    rst_n = 1'b1;

    // MANUAL sweep of S on A (S=7 is the last legal index, no sel_err)
    en_a = 1'b1;
    for (int s = 0; s < 8; s++) begin
      s_a = 3'(s);
      exp_s(0, exp1[s], 3'(s), 0, 0, "manual");
      step();
    end
    en_a = 1'b0;
    step();

    // Bad selects on B (N_CH=6): 7 and 6 are illegal
    en_b = 1'b1;
    s_b = 3'd7; chk(1, 4'd0, 3'd7, 0, 1, 0, "bad_sel7"); step();
    s_b = 3'd2; exp_s(1, 4'd11, 3'd2, 0, 0, "sel2_after_bad"); step();
    s_b = 3'd5; exp_s(1, 4'd14, 3'd5, 0, 0, "sel5_last"); step();
    s_b = 3'd6; chk(1, 4'd0, 3'd6, 0, 1, 0, "bad_sel6"); step();

    // SCAN on B with DWELL=1: strobe every cycle, sel_err cleared on entry
    mode_b = 1'b1;
    chk(1, 4'd9, 3'd0, 0, 0, 0, "b_scan_entry"); step();
    for (int j = 0; j < 7; j++) begin
      exp_s(1, 4'(9 + (j % 6)), 3'(j % 6), (j == 5), 0, "b_scan");
      step();
    end
    en_b = 1'b0; mode_b = 1'b0;
    step();

    // SCAN on A, I[k]=k+1
    for (int k = 0; k < 8; k++) i_a[k*4 +: 4] = 4'(k + 1);
    mode_a = 1'b1; en_a = 1'b1;
    chk(0, 4'd1, 3'd0, 0, 0, 0, "a_scan_entry"); step();
    for (int j = 1; j <= 78; j++) begin
      ch = ((j - 1) / 4) % 8;
      if (j == 1) chk(0, 4'd1, 3'd0, 0, 0, 0, "a_scan_d0");
      if (j % 4 == 0) exp_s(0, 4'(ch + 1), 3'(ch), (ch == 7), 0, "scan");
      step();
    end

    // Drop to MANUAL at ch 3 / dwell 2, then re-enter SCAN from ch 0
    mode_a = 1'b0; s_a = 3'd5;
    exp_s(0, 4'd6, 3'd5, 0, 0, "drop_manual"); step();
    mode_a = 1'b1;
    chk(0, 4'd1, 3'd0, 0, 0, 0, "restart_entry"); step();
    for (int j = 1; j <= 12; j++) begin
      if (j % 4 == 0) exp_s(0, 4'(j / 4), 3'(j / 4 - 1), 0, 0, "restart");
      step();
    end

    // Freeze right after a strobe
    en_a = 1'b0;
    for (int j = 0; j < 5; j++) begin
      chk(0, 4'd3, 3'd2, 0, 0, 0, "frozen");
      step();
    end
    en_a = 1'b1;
    for (int j = 13; j <= 16; j++) begin
      if (j == 13) chk(0, 4'd4, 3'd3, 0, 0, 0, "resume_d0");
      if (j == 16) exp_s(0, 4'd4, 3'd3, 0, 0, "resume");
      step();
    end

    // Reset during SCAN with en=0
    en_a = 1'b0; rst_n = 1'b0;
    chk(0, 4'd0, 3'd0, 0, 0, 0, "rst_scan_a");
    chk(1, 4'd0, 3'd0, 0, 0, 0, "rst_scan_b");
    step();
    rst_n = 1'b1;
    chk(0, 4'd0, 3'd0, 0, 0, 0, "rst_hold"); step();
    en_a = 1'b1;
    chk(0, 4'd1, 3'd0, 0, 0, 0, "post_rst_entry"); step();
    for (int j = 1; j <= 4; j++) begin
      if (j == 4) exp_s(0, 4'd1, 3'd0, 0, 0, "post_rst_strobe");
      step();
    end
    en_a = 1'b0; mode_a = 1'b0;
    step(); step();
    done = 1'b1;
  end
endmodule
